// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the conv/pool + DNN core: streams one image per frame from the host,
// forwards DNN results, then soft-resets the core before the next frame of the run.
module cnn_frame_sequencer #(
    parameter int BitSize       = 32,
    parameter int ImageWidth    = 8,
    parameter int NumOut        = 2,
    parameter int ResetCycles   = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic                      start,
    input  logic [7:0]                num_frames,
    input  logic                      host_valid,
    input  logic [BitSize-1:0]        host_data,
    output logic                      host_ready,
    output logic                      core_res_n,
    output logic                      core_in_valid,
    output logic [BitSize-1:0]        core_in_data,
    input  logic                      core_ready,
    input  logic                      core_out_valid,
    input  logic [NumOut*BitSize-1:0] core_out_data,
    input  logic                      core_out_done,
    output logic                      res_valid,
    output logic [NumOut*BitSize-1:0] res_data,
    output logic                      frame_done,
    output logic                      run_done,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int FramePixels = ImageWidth * ImageWidth;
    localparam int PixW        = $clog2(FramePixels + 1);
    localparam int ToW         = $clog2(TimeoutCycles + 1);
    localparam int RstW        = $clog2(ResetCycles + 1);

    localparam logic [PixW-1:0] PixLast = PixW'(FramePixels - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TimeoutCycles - 1);
    localparam logic [RstW-1:0] RstLast = RstW'(ResetCycles - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RST} state_t;

    state_t          state, state_next;
    logic [7:0]      frames_left;
    logic [PixW-1:0] pix_cnt;
    logic [ToW-1:0]  to_cnt;
    logic [RstW-1:0] rst_cnt;

    logic start_ok;
    logic frame_end;
    logic frame_timeout;
    logic run_end;

    assign start_ok = (state == IDLE) && start && (num_frames != 8'd0);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next    = state;
        host_ready    = 1'b0;
        core_in_valid = 1'b0;
        core_in_data  = host_data;
        frame_end     = 1'b0;
        frame_timeout = 1'b0;
        run_end       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_frames != 8'd0) state_next = STREAM;
                    else                    run_end    = 1'b1;
                end
            end
            STREAM: begin
                host_ready    = core_ready;
                core_in_valid = host_valid && core_ready;
                if (core_in_valid && (pix_cnt == PixLast)) state_next = DRAIN;
            end
            DRAIN: begin
                // A done flag arriving on the timeout cycle wins over the timeout.
                if (core_out_done) begin
                    frame_end  = 1'b1;
                    state_next = RST;
                end else if (to_cnt == ToLast) begin
                    frame_end     = 1'b1;
                    frame_timeout = 1'b1;
                    state_next    = RST;
                end
            end
            RST: begin
                if (rst_cnt == RstLast) begin
                    if (frames_left == 8'd1) begin
                        state_next = IDLE;
                        run_end    = 1'b1;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state       <= IDLE;
            core_res_n  <= 1'b0;
            frame_done  <= 1'b0;
            run_done    <= 1'b0;
            timeout_err <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            state      <= state_next;
            // Registered from the next state so the core sees reset exactly while in RST.
            core_res_n <= (state_next != RST);
            frame_done <= frame_end;
            run_done   <= run_end;
            res_valid  <= (state == DRAIN) && core_out_valid;
            if (state == DRAIN) res_data <= core_out_data;
            if (start_ok)           timeout_err <= 1'b0;
            else if (frame_timeout) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            frames_left <= '0;
            pix_cnt     <= '0;
            to_cnt      <= '0;
            rst_cnt     <= '0;
        end else begin
            if (start_ok)
                frames_left <= num_frames;
            else if ((state == RST) && (rst_cnt == RstLast) && (frames_left != 8'd1))
                frames_left <= frames_left - 8'd1;

            if (start_ok)
                pix_cnt <= '0;
            else if (core_in_valid)
                pix_cnt <= (pix_cnt == PixLast) ? '0 : pix_cnt + PixW'(1);

            to_cnt  <= (state == DRAIN) ? to_cnt + ToW'(1) : '0;
            rst_cnt <= (state == RST) ? rst_cnt + RstW'(1) : '0;
        end
    end

endmodule
